// File: rtl/adder_share_ctrl_pkg.sv
// adder_pkg: shared types and constants for the shared nibble adder.
//   state_t  - controller states (IDLE, ADD, RESP)
//   SLICE_W  - width of the shared ripple-carry slice
//   nibbles  - number of slice passes needed for a given operand width
package adder_pkg;
  typedef enum logic [1:0] {IDLE, ADD, RESP} state_t;

  localparam int SLICE_W = 4;

  function automatic int nibbles(input int width);
    return width / SLICE_W;
  endfunction
endpackage

// File: rtl/adder_share_ctrl_if.sv
// adder_share_ctrl_if: request/response bundle for adder_share_ctrl.
//   req0_*/req1_* : two valid/ready operand channels (a, b are WIDTH bits)
//   resp_*        : valid/ready result channel; resp_sum is WIDTH+1 bits,
//                   resp_id names the requester that owns the result
//   master        : producer/consumer side
//   slave         : the adder controller
interface adder_share_ctrl_if #(parameter int WIDTH = 16);
  logic             req0_valid, req0_ready;
  logic [WIDTH-1:0] req0_a, req0_b;
  logic             req1_valid, req1_ready;
  logic [WIDTH-1:0] req1_a, req1_b;
  logic             resp_valid, resp_ready, resp_id;
  logic [WIDTH:0]   resp_sum;

  modport master (
    output req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b, resp_ready,
    input  req0_ready, req1_ready, resp_valid, resp_id, resp_sum
  );

  modport slave (
    input  req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b, resp_ready,
    output req0_ready, req1_ready, resp_valid, resp_id, resp_sum
  );
endinterface

// File: rtl/adder_share_ctrl_slice.sv
// add_slice4: combinational 4-bit ripple-carry adder slice.
//   a, b : nibble operands
//   cin  : carry in
//   sum  : nibble result
//   cout : carry out of the top bit
module add_slice4
  import adder_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               cin,
  output logic [SLICE_W-1:0] sum,
  output logic               cout
);
  logic [SLICE_W:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < SLICE_W; i++) begin : g_bit
    assign sum[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout = c[SLICE_W];
endmodule

// File: rtl/adder_share_ctrl.sv
// adder_share_ctrl: two requesters share one 4-bit slice via round-robin.
// A granted add runs one nibble per clock, LS nibble first, then holds the
// WIDTH+1-bit result on the response channel until the consumer takes it.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : adder_share_ctrl_if.slave (req0, req1, resp channels)
module adder_share_ctrl
  import adder_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  adder_share_ctrl_if.slave  bus
);
  localparam int NIBBLES = nibbles(WIDTH);
  localparam int CW      = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  if (WIDTH < SLICE_W || (WIDTH % SLICE_W) != 0) begin : g_bad_width
    $error("adder_share_ctrl: WIDTH must be a positive multiple of 4");
  end

  state_t           state;
  logic             last_grant;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic [WIDTH-1:0] a_r, b_r;
  logic             id_r;
  logic [WIDTH:0]   sum_r;
  logic             resp_valid_r;

  // Round-robin: a lone requester always wins; on a tie, whoever did not
  // win last time goes.
  logic g0, g1;
  assign g0 = bus.req0_valid && (!bus.req1_valid || last_grant);
  assign g1 = bus.req1_valid && (!bus.req0_valid || !last_grant);

  assign bus.req0_ready = (state == IDLE) && g0;
  assign bus.req1_ready = (state == IDLE) && g1;
  assign bus.resp_valid = resp_valid_r;
  assign bus.resp_id    = id_r;
  assign bus.resp_sum   = sum_r;

  // The single slice sees the nibble selected by the pass counter.
  logic [SLICE_W-1:0] s_a, s_b, s_sum;
  logic               s_cout;
  assign s_a = a_r[int'(cnt)*SLICE_W +: SLICE_W];
  assign s_b = b_r[int'(cnt)*SLICE_W +: SLICE_W];

  add_slice4 u_slice (
    .a    (s_a),
    .b    (s_b),
    .cin  (carry),
    .sum  (s_sum),
    .cout (s_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      last_grant   <= 1'b1;
      cnt          <= '0;
      carry        <= 1'b0;
      a_r          <= '0;
      b_r          <= '0;
      id_r         <= 1'b0;
      sum_r        <= '0;
      resp_valid_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (g0 || g1) begin
            a_r        <= g1 ? bus.req1_a : bus.req0_a;
            b_r        <= g1 ? bus.req1_b : bus.req0_b;
            id_r       <= g1;
            last_grant <= g1;
            carry      <= 1'b0;
            cnt        <= '0;
            sum_r      <= '0;
            state      <= ADD;
          end
        end
        ADD: begin
          sum_r[int'(cnt)*SLICE_W +: SLICE_W] <= s_sum;
          carry <= s_cout;
          cnt   <= cnt + 1'b1;
          if (cnt == CW'(NIBBLES - 1)) begin
            sum_r[WIDTH] <= s_cout;
            cnt          <= '0;
            resp_valid_r <= 1'b1;
            state        <= RESP;
          end
        end
        RESP: begin
          if (bus.resp_ready) begin
            resp_valid_r <= 1'b0;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_adder_share_ctrl.sv
// tb_adder_share_ctrl: directed bench for adder_share_ctrl (WIDTH=16 and a
// WIDTH=4 instance), with a randomised round-robin section.
module tb_adder_share_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  adder_share_ctrl_if #(.WIDTH(16)) bus16 ();
  adder_share_ctrl_if #(.WIDTH(4))  bus4 ();

  adder_share_ctrl #(.WIDTH(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16));
  adder_share_ctrl #(.WIDTH(4))  dut4  (.clk(clk), .rst_n(rst_n), .bus(bus4));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    bus16.req0_valid = 0; bus16.req0_a = '0; bus16.req0_b = '0;
    bus16.req1_valid = 0; bus16.req1_a = '0; bus16.req1_b = '0;
    bus16.resp_ready = 0;
    bus4.req0_valid  = 0; bus4.req0_a  = '0; bus4.req0_b  = '0;
    bus4.req1_valid  = 0; bus4.req1_a  = '0; bus4.req1_b  = '0;
    bus4.resp_ready  = 0;
  endtask

  task automatic do_reset;
    rst_n = 0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
  endtask

  // Bounded wait for resp_valid on the 16-bit instance; a timeout is a failure.
  task automatic wait_valid(input string tag);
    bit ok;
    ok = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus16.resp_valid) begin ok = 1; break; end
      tick();
    end
    check(tag, 32'(ok), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          v0, v1, w, lg, done;
    logic [15:0] a0, b0, a1, b1;
    logic [31:0] exp;

    // Reset state
    rst_n = 0;
    idle_inputs();
    #1;
    check("rst_valid", 32'(bus16.resp_valid), 0);
    check("rst_sum",   32'(bus16.resp_sum),   0);
    check("rst_id",    32'(bus16.resp_id),    0);
    check("rst_rdy0",  32'(bus16.req0_ready), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1;

    // 1: 0xFFFF + 0x0001, latency 4 edges
    bus16.req0_a = 16'hFFFF; bus16.req0_b = 16'h0001; bus16.req0_valid = 1;
    bus16.resp_ready = 1;
    #1;
    check("t1_rdy0", 32'(bus16.req0_ready), 1);
    check("t1_rdy1", 32'(bus16.req1_ready), 0);
    tick();
    bus16.req0_valid = 0; bus16.req0_a = 16'h0000;  // must not affect result
    for (int i = 0; i < 4; i++) begin
      check("t1_lat", 32'(bus16.resp_valid), 0);
      tick();
    end
    check("t1_valid", 32'(bus16.resp_valid), 1);
    check("t1_sum",   32'(bus16.resp_sum),   32'h10000);
    check("t1_id",    32'(bus16.resp_id),    0);
    tick();
    check("t1_drop",  32'(bus16.resp_valid), 0);
    check("t1_keep",  32'(bus16.resp_sum),   32'h10000);

    // 2: both valid from reset
    do_reset();
    bus16.req0_a = 16'h0F0F; bus16.req0_b = 16'h00F1; bus16.req0_valid = 1;
    bus16.req1_a = 16'h1234; bus16.req1_b = 16'h4321; bus16.req1_valid = 1;
    bus16.resp_ready = 1;
    #1;
    check("t2_rdy0", 32'(bus16.req0_ready), 1);
    check("t2_rdy1", 32'(bus16.req1_ready), 0);
    tick();
    bus16.req0_valid = 0;
    wait_valid("t2_wait0");
    check("t2_id0",  32'(bus16.resp_id),  0);
    check("t2_sum0", 32'(bus16.resp_sum), 32'h01000);
    tick();
    check("t2_drop", 32'(bus16.resp_valid), 0);
    check("t2_rdy1b", 32'(bus16.req1_ready), 1);
    tick();
    bus16.req1_valid = 0;
    wait_valid("t2_wait1");
    check("t2_id1",  32'(bus16.resp_id),  1);
    check("t2_sum1", 32'(bus16.resp_sum), 32'h05555);
    tick();
    bus16.req0_a = 16'hABCD; bus16.req0_b = 16'h1234; bus16.req0_valid = 1;
    bus16.req1_a = 16'hFFFF; bus16.req1_b = 16'hFFFF; bus16.req1_valid = 1;
    bus16.resp_ready = 0;
    #1;
    check("t2_rr0", 32'(bus16.req0_ready), 1);
    check("t2_rr1", 32'(bus16.req1_ready), 0);
    tick();
    bus16.req0_valid = 0;

    // 3: backpressure with req1 still pending
    wait_valid("t3_wait");
    check("t3_sum", 32'(bus16.resp_sum), 32'h0BE01);
    check("t3_id",  32'(bus16.resp_id),  0);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("t3_hold_v",  32'(bus16.resp_valid), 1);
      check("t3_hold_s",  32'(bus16.resp_sum),   32'h0BE01);
      check("t3_hold_id", 32'(bus16.resp_id),    0);
      check("t3_rdy0",    32'(bus16.req0_ready), 0);
      check("t3_rdy1",    32'(bus16.req1_ready), 0);
    end
    bus16.resp_ready = 1;
    tick();
    check("t3_drop", 32'(bus16.resp_valid), 0);
    check("t3_keep", 32'(bus16.resp_sum),   32'h0BE01);
    check("t3_rdy1b", 32'(bus16.req1_ready), 1);
    tick();
    bus16.req1_valid = 0;
    wait_valid("t3_wait1");
    check("t3_sum1", 32'(bus16.resp_sum), 32'h1FFFE);
    check("t3_id1",  32'(bus16.resp_id),  1);
    tick();

    // 4: reset at counter=2 aborts the add
    bus16.req0_a = 16'h1234; bus16.req0_b = 16'h1111; bus16.req0_valid = 1;
    tick();
    bus16.req0_valid = 0;
    tick();
    tick();
    rst_n = 0;
    #1;
    check("t4_rst_v",  32'(bus16.resp_valid), 0);
    check("t4_rst_s",  32'(bus16.resp_sum),   0);
    check("t4_rst_id", 32'(bus16.resp_id),    0);
    @(posedge clk);
    #1 rst_n = 1;
    for (int i = 0; i < 6; i++) begin
      check("t4_noresp", 32'(bus16.resp_valid), 0);
      tick();
    end
    bus16.req1_a = 16'h8000; bus16.req1_b = 16'h8000; bus16.req1_valid = 1;
    #1;
    check("t4_rdy1", 32'(bus16.req1_ready), 1);
    tick();
    bus16.req1_valid = 0;
    wait_valid("t4_wait");
    check("t4_sum", 32'(bus16.resp_sum), 32'h10000);
    check("t4_id",  32'(bus16.resp_id),  1);
    tick();

    // 5: random operands/requesters/backpressure; losers stay valid
    lg = 1; v0 = 0; v1 = 0; a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    for (int it = 0; it < 500; it++) begin
      if (!v0 && $urandom_range(0, 1) == 1) begin v0 = 1; a0 = 16'($urandom); b0 = 16'($urandom); end
      if (!v1 && $urandom_range(0, 1) == 1) begin v1 = 1; a1 = 16'($urandom); b1 = 16'($urandom); end
      if (!v0 && !v1) begin v0 = 1; a0 = 16'($urandom); b0 = 16'($urandom); end
      bus16.req0_valid = v0; bus16.req0_a = a0; bus16.req0_b = b0;
      bus16.req1_valid = v1; bus16.req1_a = a1; bus16.req1_b = b1;
      bus16.resp_ready = 0;
      #1;
      w = (v0 && v1) ? !lg : v1;
      exp = w ? (32'(a1) + 32'(b1)) : (32'(a0) + 32'(b0));
      check("rnd_rdy0", 32'(bus16.req0_ready), 32'(!w));
      check("rnd_rdy1", 32'(bus16.req1_ready), 32'(w));
      tick();
      lg = w;
      if (w) v1 = 0; else v0 = 0;
      bus16.req0_valid = v0;
      bus16.req1_valid = v1;
      done = 0;
      for (int c = 0; c < 60 && !done; c++) begin
        bus16.resp_ready = 1'($urandom_range(0, 1));
        if (bus16.resp_valid && bus16.resp_ready) begin
          check("rnd_sum", 32'(bus16.resp_sum), exp);
          check("rnd_id",  32'(bus16.resp_id),  32'(w));
          done = 1;
        end
        tick();
      end
      check("rnd_timeout", 32'(done), 1);
    end
    idle_inputs();

    // 6: WIDTH=4 exhaustive through req1
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        bus4.req1_a = 4'(a); bus4.req1_b = 4'(b); bus4.req1_valid = 1;
        bus4.resp_ready = 1;
        #1;
        check("w4_rdy1", 32'(bus4.req1_ready), 1);
        tick();
        bus4.req1_valid = 0;
        check("w4_lat", 32'(bus4.resp_valid), 0);
        tick();
        check("w4_valid", 32'(bus4.resp_valid), 1);
        check("w4_sum",   32'(bus4.resp_sum),   32'(a + b));
        check("w4_id",    32'(bus4.resp_id),    1);
        tick();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
